// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch (IFU) and the
// load/store path (LSU). One outstanding transaction at a time; LSU has priority,
// but after MAX_LSU_BURST consecutive LSU wins over a waiting IFU, the IFU is
// forced a turn. A watchdog aborts transactions that stall for TIMEOUT cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ifu_*               fetch request / grant / response channel
//   lsu_*               load/store request / grant / response channel
//   bus_*               shared memory bus master interface
//   hold_o              stall request to pipeline control while an LSU access is pending
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_LSU_BURST = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_gnt,
  output logic                ifu_rvalid,
  output logic                ifu_err,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic                lsu_err,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                hold_o
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned SwW  = (MAX_LSU_BURST > 0) ? $clog2(MAX_LSU_BURST + 1) : 1;
  // wd_cnt never exceeds TIMEOUT-1, so $clog2(TIMEOUT) bits are enough.
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SwW-1:0] StarveMax = SwW'(MAX_LSU_BURST);
  localparam logic [WdW-1:0] WdLast    = WdW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e            state_q, state_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic [SwW-1:0]    starve_q, starve_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [BeW-1:0]    bus_be_q, bus_be_d;

  logic sel_lsu, sel_ifu, stall, wd_abort, addr_done, data_done;

  always_comb begin
    // IFU only wins against a pending LSU once it has been passed over MAX_LSU_BURST times.
    sel_lsu   = lsu_req && !(ifu_req && (starve_q == StarveMax));
    sel_ifu   = !sel_lsu && ifu_req;
    addr_done = (state_q == StAddr) && bus_gnt;
    data_done = (state_q == StData) && bus_rvalid;
    stall     = ((state_q == StAddr) && !bus_gnt) || ((state_q == StData) && !bus_rvalid);
    wd_abort  = (TIMEOUT != 0) && stall && (wd_q == WdLast);
  end

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    starve_d    = starve_q;
    wd_d        = wd_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;

    unique case (state_q)
      StIdle: begin
        if (sel_lsu) begin
          owner_lsu_d = 1'b1;
          bus_we_d    = lsu_we;
          bus_addr_d  = lsu_addr;
          bus_wdata_d = lsu_wdata;
          bus_be_d    = lsu_be;
          state_d     = StAddr;
          wd_d        = '0;
          if (!ifu_req) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + SwW'(1);
          end
        end else if (sel_ifu) begin
          owner_lsu_d = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = ifu_addr;
          bus_wdata_d = '0;
          bus_be_d    = '1;
          state_d     = StAddr;
          wd_d        = '0;
          starve_d    = '0;
        end
      end
      StAddr: begin
        if (bus_gnt) begin
          state_d = StData;
          wd_d    = '0;
        end else if (wd_abort) begin
          state_d = StIdle;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StData: begin
        if (bus_rvalid || wd_abort) begin
          state_d = StIdle;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_lsu_q <= 1'b0;
      starve_q    <= '0;
      wd_q        <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      starve_q    <= starve_d;
      wd_q        <= wd_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  // Requester-side outputs are gated by rst so nothing is forwarded while reset is held.
  always_comb begin
    bus_req    = (state_q == StAddr);
    bus_we     = bus_we_q;
    bus_addr   = bus_addr_q;
    bus_wdata  = bus_wdata_q;
    bus_be     = bus_be_q;
    lsu_gnt    = rst && owner_lsu_q && addr_done;
    ifu_gnt    = rst && !owner_lsu_q && addr_done;
    lsu_rvalid = rst && owner_lsu_q && data_done;
    ifu_rvalid = rst && !owner_lsu_q && data_done;
    lsu_err    = rst && owner_lsu_q && wd_abort;
    ifu_err    = rst && !owner_lsu_q && wd_abort;
    lsu_rdata  = lsu_rvalid ? bus_rdata : '0;
    ifu_rdata  = ifu_rvalid ? bus_rdata : '0;
    hold_o     = rst && (((state_q == StIdle) && lsu_req) ||
                         (owner_lsu_q && (state_q != StIdle) && !data_done && !wd_abort));
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for arbitration fairness, delayed grant, watchdog and reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt, ifu_rvalid, ifu_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_be;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        hold_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_LSU_BURST(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid),
    .ifu_err(ifu_err), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_err(lsu_err),
    .lsu_rdata(lsu_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .hold_o(hold_o)
  );

  typedef struct packed {
    logic        lreq;
    logic        lwe;
    logic [31:0] laddr;
    logic        ireq;
    logic [31:0] iaddr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_breq;
    logic        e_bwe;
    logic [31:0] e_baddr;
    logic        e_lgnt;
    logic        e_ignt;
    logic        e_lrv;
    logic        e_irv;
    logic        e_hold;
    logic [31:0] e_lrdata;
    logic [31:0] e_irdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_be = 4'hF;
    ifu_req = 0; ifu_addr = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int lsu_n;
    int gcount;

    //             lreq lwe laddr      ireq iaddr     gnt rv rdata
    //             breq bwe baddr      lgnt ignt lrv irv hold lrdata irdata
    vecs[0]  = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF,
                 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h55,
                 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'hCAFE0001,
                 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hCAFE0001};
    vecs[8]  = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 1'b1, 32'h77,
                 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,
                 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h0,
                 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    // Reset state
    rst = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_be", bus_be, 0);
    chk("rst hold", hold_o, 0);
    chk("rst lsu_rvalid", lsu_rvalid, 0);
    step();
    rst = 1;

    // Vector table, one entry per clock cycle
    for (int i = 0; i < 13; i++) begin
      lsu_req = vecs[i].lreq; lsu_we = vecs[i].lwe; lsu_addr = vecs[i].laddr;
      ifu_req = vecs[i].ireq; ifu_addr = vecs[i].iaddr;
      bus_gnt = vecs[i].gnt; bus_rvalid = vecs[i].rv; bus_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d bus_req", i), bus_req, vecs[i].e_breq);
      chk($sformatf("v%0d bus_we", i), bus_we, vecs[i].e_bwe);
      chk($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].e_baddr);
      chk($sformatf("v%0d lsu_gnt", i), lsu_gnt, vecs[i].e_lgnt);
      chk($sformatf("v%0d ifu_gnt", i), ifu_gnt, vecs[i].e_ignt);
      chk($sformatf("v%0d lsu_rvalid", i), lsu_rvalid, vecs[i].e_lrv);
      chk($sformatf("v%0d ifu_rvalid", i), ifu_rvalid, vecs[i].e_irv);
      chk($sformatf("v%0d hold", i), hold_o, vecs[i].e_hold);
      chk($sformatf("v%0d lsu_rdata", i), lsu_rdata, vecs[i].e_lrdata);
      chk($sformatf("v%0d ifu_rdata", i), ifu_rdata, vecs[i].e_irdata);
      chk($sformatf("v%0d errs", i), {lsu_err, ifu_err}, 0);
      step();
    end

    // Fairness: both requesters held, slave always ready -> L L L L I L L L L I
    idle_inputs();
    lsu_req = 1; lsu_addr = 32'h600; ifu_req = 1; ifu_addr = 32'h700;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h11112222;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      @(negedge clk);
      if (lsu_gnt || ifu_gnt) begin
        chk($sformatf("arb grant%0d is_lsu", n), lsu_gnt, (n % 5) != 4);
        chk($sformatf("arb grant%0d onehot", n), lsu_gnt & ifu_gnt, 0);
        n++;
      end
      if (lsu_rvalid) begin
        chk("arb ifu_rdata on lsu", ifu_rdata, 0);
        chk("arb lsu_rdata", lsu_rdata, 32'h11112222);
      end
      step();
    end
    chk("arb grant count", n, 10);
    lsu_req = 0; ifu_req = 0;
    step();
    idle_inputs();
    step();

    // Store with bus_gnt delayed 3 cycles
    lsu_req = 1; lsu_we = 1; lsu_be = 4'h3; lsu_wdata = 32'h1234; lsu_addr = 32'h400;
    @(negedge clk);
    chk("st idle hold", hold_o, 1);
    step();
    gcount = 0;
    for (int k = 0; k < 4; k++) begin
      bus_gnt = (k == 3);
      @(negedge clk);
      chk($sformatf("st a%0d bus_req", k), bus_req, 1);
      chk($sformatf("st a%0d bus_we", k), bus_we, 1);
      chk($sformatf("st a%0d bus_be", k), bus_be, 4'h3);
      chk($sformatf("st a%0d bus_wdata", k), bus_wdata, 32'h1234);
      chk($sformatf("st a%0d bus_addr", k), bus_addr, 32'h400);
      chk($sformatf("st a%0d hold", k), hold_o, 1);
      chk($sformatf("st a%0d lsu_gnt", k), lsu_gnt, k == 3);
      if (lsu_gnt) gcount++;
      step();
    end
    lsu_req = 0; lsu_we = 0; bus_gnt = 0; bus_rvalid = 1;
    @(negedge clk);
    chk("st ack rvalid", lsu_rvalid, 1);
    chk("st ack hold", hold_o, 0);
    chk("st ack bus_req", bus_req, 0);
    if (lsu_gnt) gcount++;
    chk("st gnt count", gcount, 1);
    step();
    idle_inputs();

    // Watchdog: grant, then no rvalid -> err on 8th DATA cycle
    lsu_req = 1; lsu_addr = 32'h500;
    step();
    bus_gnt = 1;
    @(negedge clk);
    chk("wd lsu_gnt", lsu_gnt, 1);
    step();
    lsu_req = 0; bus_gnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("wd d%0d err", k), lsu_err, k == 8);
      chk($sformatf("wd d%0d rvalid", k), lsu_rvalid, 0);
      chk($sformatf("wd d%0d hold", k), hold_o, k != 8);
      chk($sformatf("wd d%0d rdata", k), lsu_rdata, 0);
      step();
    end
    ifu_req = 1; ifu_addr = 32'h800;
    @(negedge clk);
    chk("wd post bus_req", bus_req, 0);
    chk("wd post err", lsu_err, 0);
    step();
    bus_gnt = 1;
    @(negedge clk);
    chk("wd ifu_gnt", ifu_gnt, 1);
    chk("wd ifu bus_addr", bus_addr, 32'h800);
    step();
    ifu_req = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hBEEF0008;
    @(negedge clk);
    chk("wd ifu_rvalid", ifu_rvalid, 1);
    chk("wd ifu_rdata", ifu_rdata, 32'hBEEF0008);
    step();
    idle_inputs();

    // Reset in DATA after 4 LSU wins (starve saturated); reset must clear it
    lsu_req = 1; lsu_addr = 32'h900; ifu_req = 1; ifu_addr = 32'hA00;
    bus_gnt = 1; bus_rvalid = 1;
    lsu_n = 0;
    for (int cyc = 0; cyc < 60 && lsu_n < 4; cyc++) begin
      @(negedge clk);
      if (lsu_gnt) lsu_n++;
      step();
    end
    chk("rd lsu wins", lsu_n, 4);
    rst = 0; bus_gnt = 0; bus_rvalid = 0;
    @(negedge clk);
    chk("rd in-reset rvalid", lsu_rvalid, 0);
    step();
    rst = 1; lsu_req = 0; ifu_req = 0; bus_rvalid = 1; bus_rdata = 32'h99;
    @(negedge clk);
    chk("rd post lsu_rvalid", lsu_rvalid, 0);
    chk("rd post ifu_rvalid", ifu_rvalid, 0);
    chk("rd post lsu_rdata", lsu_rdata, 0);
    chk("rd post bus_req", bus_req, 0);
    chk("rd post bus_addr", bus_addr, 0);
    chk("rd post hold", hold_o, 0);
    step();
    bus_rvalid = 0; lsu_req = 1; ifu_req = 1; bus_gnt = 1;
    @(negedge clk);
    chk("rd arb hold", hold_o, 1);
    step();
    @(negedge clk);
    chk("rd arb lsu_gnt", lsu_gnt, 1);
    chk("rd arb ifu_gnt", ifu_gnt, 0);
    step();
    lsu_req = 0; ifu_req = 0; bus_gnt = 0; bus_rvalid = 1;
    step();
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
